pb_eject_sink: RTL and testbench

// - Parametrised termination endpoint for router Eject ports of tiles without a real endpoint.

---
 rtl/pb_eject_sink_pkg.sv | 15 +
 rtl/pb_eject_sink_chan.sv | 139 +++++++++++++
 rtl/pb_eject_sink.sv | 53 +++++
 tb/tb_pb_eject_sink.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pb_eject_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picobello_pkg
// Description : Shared types for the eject sink (channel FSM states, channel count).
// Revision    : 1.0 - initial release
// ============================================================================
package picobello_pkg;

    typedef enum logic [0:0] {SinkAccept = 1'b0, SinkStall = 1'b1} sink_state_e;

    // req, rsp, wide
    localparam int unsigned EjectNumChannels = 3;

endpackage
`default_nettype wire

// File: rtl/pb_eject_sink_chan.sv
`default_nettype none
// ============================================================================
// Module      : pb_eject_sink_chan
// Description : One eject sink channel: stall FSM, saturating counter, capture,
//               protocol checker and optional checksum (PB_EJECT_SINK_CHECKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pb_eject_sink_chan
    import picobello_pkg::*;
#(
    parameter int unsigned FlitWidth  = 64,
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned StallWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [StallWidth-1:0] stall_cycles_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [FlitWidth-1:0]  data_i,
    output logic [CntWidth-1:0]   count_o,
    output logic [FlitWidth-1:0]  last_data_o,
    output logic                  proto_err_o,
    output logic [FlitWidth-1:0]  checksum_o
);

    localparam logic [CntWidth-1:0]   c_CNT_MAX   = {CntWidth{1'b1}};
    localparam logic [StallWidth-1:0] c_STALL_ONE = {{(StallWidth-1){1'b0}}, 1'b1};

    sink_state_e           r_state;
    sink_state_e           w_state_nxt;
    logic [StallWidth-1:0] r_stall_cnt;
    logic [StallWidth-1:0] w_stall_cnt_nxt;
    logic                  w_ready;
    logic                  w_xfer;
    logic [CntWidth-1:0]   r_count;
    logic [FlitWidth-1:0]  r_last_data;
    logic                  r_proto_err;
    logic                  r_prev_valid;
    logic                  r_prev_ready;
    logic [FlitWidth-1:0]  r_prev_data;
    logic                  w_violation;

    // Ready is masked during reset even though the state register already reads ACCEPT.
    assign w_ready = !rst_i && (r_state == SinkAccept) && enable_i;
    assign w_xfer  = valid_i && w_ready;
    assign ready_o = w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= SinkAccept;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        case (r_state)
            SinkAccept: begin
                if (w_xfer && (stall_cycles_i != '0)) begin
                    w_state_nxt     = SinkStall;
                    w_stall_cnt_nxt = stall_cycles_i;
                end
            end
            SinkStall: begin
                w_stall_cnt_nxt = r_stall_cnt - c_STALL_ONE;
                if (r_stall_cnt <= c_STALL_ONE) begin
                    w_state_nxt = SinkAccept;
                end
            end
            default: begin
                w_state_nxt     = SinkAccept;
                w_stall_cnt_nxt = '0;
            end
        endcase
    end

    // A flit offered without ready must be held unchanged until accepted.
    assign w_violation = r_prev_valid && !r_prev_ready &&
                         (!valid_i || (data_i != r_prev_data));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count      <= '0;
            r_last_data  <= '0;
            r_proto_err  <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_ready <= 1'b0;
            r_prev_data  <= '0;
        end else begin
            r_prev_valid <= valid_i;
            r_prev_ready <= w_ready;
            r_prev_data  <= data_i;
            if (clear_i) begin
                r_count     <= '0;
                r_last_data <= '0;
                r_proto_err <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_last_data <= data_i;
                    if (r_count != c_CNT_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                if (w_violation) begin
                    r_proto_err <= 1'b1;
                end
            end
        end
    end

    assign count_o     = r_count;
    assign last_data_o = r_last_data;
    assign proto_err_o = r_proto_err;

`ifdef PB_EJECT_SINK_CHECKSUM_EN
    logic [FlitWidth-1:0] r_checksum;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ data_i;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/pb_eject_sink.sv
`default_nettype none
// ============================================================================
// Module      : pb_eject_sink
// Description : Counting, flow-controlled termination for unused router Eject
//               ports; checksum enabled by PB_EJECT_SINK_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_eject_sink
    import picobello_pkg::*;
#(
    parameter int unsigned NumChannels = EjectNumChannels,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned StallWidth  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic [NumChannels-1:0]           enable_i,
    input  logic [StallWidth-1:0]            stall_cycles_i,
    input  logic [NumChannels-1:0]           valid_i,
    output logic [NumChannels-1:0]           ready_o,
    input  logic [NumChannels*FlitWidth-1:0] data_i,
    output logic [NumChannels*CntWidth-1:0]  count_o,
    output logic [NumChannels*FlitWidth-1:0] last_data_o,
    output logic [NumChannels-1:0]           proto_err_o,
    output logic [NumChannels*FlitWidth-1:0] checksum_o
);

    // Channels are fully independent; no arbitration between them.
    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        pb_eject_sink_chan #(
            .FlitWidth  (FlitWidth),
            .CntWidth   (CntWidth),
            .StallWidth (StallWidth)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .clear_i        (clear_i),
            .enable_i       (enable_i[c]),
            .stall_cycles_i (stall_cycles_i),
            .valid_i        (valid_i[c]),
            .ready_o        (ready_o[c]),
            .data_i         (data_i[c*FlitWidth +: FlitWidth]),
            .count_o        (count_o[c*CntWidth +: CntWidth]),
            .last_data_o    (last_data_o[c*FlitWidth +: FlitWidth]),
            .proto_err_o    (proto_err_o[c]),
            .checksum_o     (checksum_o[c*FlitWidth +: FlitWidth])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_eject_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_eject_sink
// Description : Self-checking bench for pb_eject_sink against a cycle-level
//               behavioural model; checksum expectation follows PB_EJECT_SINK_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_eject_sink;

    localparam int NCH = 3;
    localparam int FW  = 16;
    localparam int CW  = 4;
    localparam int SW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [NCH-1:0]    enable = '0;
    logic [SW-1:0]     stall_cycles = '0;
    logic [NCH-1:0]    valid = '0;
    logic [NCH-1:0]    ready;
    logic [NCH*FW-1:0] data = '0;
    logic [NCH*CW-1:0] count;
    logic [NCH*FW-1:0] last_data;
    logic [NCH-1:0]    proto_err;
    logic [NCH*FW-1:0] checksum;

    int total = 0;
    int bad   = 0;

    // Behavioural model: stall_left = ready-low cycles still owed by the channel.
    int          m_stall_left [NCH];
    int          m_cnt        [NCH];
    logic [FW-1:0] m_last     [NCH];
    logic [FW-1:0] m_chk      [NCH];
    logic [FW-1:0] m_prev_d   [NCH];
    bit          m_err        [NCH];
    bit          m_prev_v     [NCH];
    bit          m_prev_r     [NCH];
    bit          exp_rdy      [NCH];
    int          rdy_hi       [NCH];

    pb_eject_sink #(
        .NumChannels (NCH),
        .FlitWidth   (FW),
        .CntWidth    (CW),
        .StallWidth  (SW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .enable_i       (enable),
        .stall_cycles_i (stall_cycles),
        .valid_i        (valid),
        .ready_o        (ready),
        .data_i         (data),
        .count_o        (count),
        .last_data_o    (last_data),
        .proto_err_o    (proto_err),
        .checksum_o     (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int ch, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s ch%0d observed=0x%0h expected=0x%0h", tag, ch, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] dslice(input int c);
        return data[c*FW +: FW];
    endfunction

    // One clock: check ready before the edge, advance the model, check state after it.
    task automatic tick();
        bit xfer [NCH];
        #1;
        for (int c = 0; c < NCH; c++) begin
            exp_rdy[c] = !rst && enable[c] && (m_stall_left[c] == 0);
            check("ready", c, 64'(ready[c]), 64'(exp_rdy[c]));
            if (ready[c]) rdy_hi[c]++;
            xfer[c] = valid[c] && exp_rdy[c];
        end
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_stall_left[c] = 0; m_cnt[c] = 0; m_last[c] = '0; m_chk[c] = '0;
                m_err[c] = 0; m_prev_v[c] = 0; m_prev_r[c] = 0; m_prev_d[c] = '0;
            end else begin
                if (clear) m_err[c] = 0;
                else if (m_prev_v[c] && !m_prev_r[c] && (!valid[c] || dslice(c) != m_prev_d[c]))
                    m_err[c] = 1;
                m_prev_v[c] = valid[c];
                m_prev_r[c] = exp_rdy[c];
                m_prev_d[c] = dslice(c);
                if (clear) begin
                    m_cnt[c] = 0; m_last[c] = '0; m_chk[c] = '0;
                end else if (xfer[c]) begin
                    m_cnt[c] = (m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX;
                    m_last[c] = dslice(c);
`ifdef PB_EJECT_SINK_CHECKSUM_EN
                    m_chk[c] = m_chk[c] ^ dslice(c);
`endif
                end
                if (m_stall_left[c] > 0) m_stall_left[c]--;
                else if (xfer[c]) m_stall_left[c] = int'(stall_cycles);
            end
        end
        #1;
        for (int c = 0; c < NCH; c++) begin
            check("count", c, 64'(count[c*CW +: CW]), 64'(m_cnt[c]));
            check("last_data", c, 64'(last_data[c*FW +: FW]), 64'(m_last[c]));
            check("proto_err", c, 64'(proto_err[c]), 64'(m_err[c]));
            check("checksum", c, 64'(checksum[c*FW +: FW]), 64'(m_chk[c]));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_stall_left[c] = 0; m_cnt[c] = 0; m_last[c] = '0; m_chk[c] = '0;
            m_err[c] = 0; m_prev_v[c] = 0; m_prev_r[c] = 0; m_prev_d[c] = '0; rdy_hi[c] = 0;
        end

        // Reset state, with enables already high: ready must stay masked.
        enable = '1;
        tick(); tick();
        check("reset_count", 0, 64'(count), 64'd0);
        check("reset_ready", 0, 64'(ready), 64'd0);
        rst = 1'b0;

        // Free flow on channel 0.
        valid = 3'b001;
        for (int i = 1; i <= 10; i++) begin
            data[0 +: FW] = FW'(i);
            tick();
        end
        valid = '0;
        check("free_count", 0, 64'(count[0 +: CW]), 64'd10);
        check("free_last", 0, 64'(last_data[0 +: FW]), 64'd10);
        check("free_ready_hi", 0, 64'(rdy_hi[0]), 64'd10);

        // Stall of 3 on channel 1 with valid held high.
        do_clear();
        stall_cycles = 8'd3;
        data[FW +: FW] = 16'h00A5;
        valid = 3'b010;
        rdy_hi[1] = 0;
        for (int i = 0; i < 16; i++) tick();
        valid = '0;
        check("stall_ready_hi", 1, 64'(rdy_hi[1]), 64'd4);
        check("stall_count", 1, 64'(count[CW +: CW]), 64'd4);
        for (int i = 0; i < 4; i++) tick();

        // Saturation on channel 0, then clear.
        stall_cycles = '0;
        valid = 3'b001;
        for (int i = 0; i < 20; i++) begin
            data[0 +: FW] = FW'($urandom);
            tick();
        end
        valid = '0;
        check("sat_count", 0, 64'(count[0 +: CW]), 64'(CNT_MAX));
        do_clear();
        check("sat_clear", 0, 64'(count[0 +: CW]), 64'd0);

        // Clear wins over a simultaneous transfer.
        valid = 3'b001; data[0 +: FW] = 16'h1234; clear = 1'b1;
        tick();
        clear = 1'b0; valid = '0;
        check("clear_xfer_count", 0, 64'(count[0 +: CW]), 64'd0);
        check("clear_xfer_last", 0, 64'(last_data[0 +: FW]), 64'd0);

        // Protocol error on channel 2: offered flit changes while blocked.
        enable = 3'b011;
        valid = 3'b100;
        data[2*FW +: FW] = 16'h0001; tick();
        check("perr_before", 2, 64'(proto_err[2]), 64'd0);
        data[2*FW +: FW] = 16'h0002; tick();
        check("perr_set", 2, 64'(proto_err[2]), 64'd1);
        valid = '0; tick(); tick();
        check("perr_sticky", 2, 64'(proto_err[2]), 64'd1);
        do_clear();
        check("perr_clear", 2, 64'(proto_err[2]), 64'd0);
        enable = '1;

        // Reset in the middle of a 200-cycle stall.
        stall_cycles = 8'd200;
        valid = 3'b001; data[0 +: FW] = 16'h0077; tick();
        valid = '0;
        for (int i = 0; i < 50; i++) tick();
        check("mid_stall_ready", 0, 64'(ready[0]), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        check("post_rst_ready", 0, 64'(ready[0]), 64'd1);
        check("post_rst_count", 0, 64'(count), 64'd0);
        check("post_rst_last", 0, 64'(last_data), 64'd0);
        tick();

        // Checksum of 0xF0 ^ 0x0F ^ 0xFF is zero in either build.
        stall_cycles = '0;
        do_clear();
        valid = 3'b001;
        data[0 +: FW] = 16'h00F0; tick();
        data[0 +: FW] = 16'h000F; tick();
        `ifdef PB_EJECT_SINK_CHECKSUM_EN
        check("chk_partial", 0, 64'(checksum[0 +: FW]), 64'h00FF);
        `endif
        data[0 +: FW] = 16'h00FF; tick();
        valid = '0;
        check("chk_final", 0, 64'(checksum[0 +: FW]), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            enable       = NCH'($urandom);
            valid        = NCH'($urandom);
            stall_cycles = SW'($urandom_range(0, 3));
            for (int c = 0; c < NCH; c++) data[c*FW +: FW] = FW'($urandom_range(0, 3));
            clear = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; clear = 1'b0; valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
